scale_selector: RTL and testbench

//   Upstream control stage for the board clock divider. Turns two raw active-low pushbuttons into a

---
 rtl/scale_selector_pkg.sv | 25 ++
 rtl/scale_selector_if.sv | 28 ++
 rtl/scale_selector_btn_debounce.sv | 59 +++++
 rtl/scale_selector.sv | 195 +++++++++++++++++++
 tb/tb_scale_selector.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/scale_selector_pkg.sv
// Shared definitions for the scale selector: FSM state encoding, default
// timing constants for the 27 MHz board and a counter-width helper.
package scale_selector_pkg;

    // FSM states of the reload sequencer
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RELOAD = 1'b1
    } state_t;

    // Defaults for the 27 MHz board: 10 ms debounce, 0.5 s auto-repeat
    localparam int DEF_WIDTH        = 8;
    localparam int DEF_DEBOUNCE_CYC = 270000;
    localparam int DEF_RELOAD_CYC   = 4;
    localparam int DEF_SCALE_MIN    = 1;
    localparam int DEF_SCALE_MAX    = 255;
    localparam int DEF_SCALE_INIT   = 4;
    localparam int DEF_REPEAT_CYC   = 13500000;

    // Bits needed for a counter holding values 0 .. n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scale_selector_if.sv
// Button/scale bundle between the pushbutton side (master) and the scale
// selector (slave). Buttons are raw and active-low; scale, reload_n and busy
// go towards the clock divider.
interface scale_selector_if #(
    parameter int WIDTH = 8
);
    logic             btn_up_n;
    logic             btn_dn_n;
    logic [WIDTH-1:0] scale;
    logic             reload_n;
    logic             busy;

    modport master (
        output btn_up_n,
        output btn_dn_n,
        input  scale,
        input  reload_n,
        input  busy
    );

    modport slave (
        input  btn_up_n,
        input  btn_dn_n,
        output scale,
        output reload_n,
        output busy
    );
endinterface

// File: rtl/scale_selector_btn_debounce.sv
// Single pushbutton conditioner: 2-FF synchronizer, debounce counter and a
// one-cycle press pulse on every accepted 1->0 transition. Releases are
// accepted the same way but produce no pulse.
module btn_debounce
    import scale_selector_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk_in,
    input  logic nrst,
    input  logic btn_n,
    output logic level_n,
    output logic press
);

    localparam int             CW   = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // Bring the asynchronous button into the clock domain; idle state is released (1)
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has differed from the accepted one for DEBOUNCE_CYC cycles
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                press_q <= level_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_n = level_q;
    assign press   = press_q;

endmodule

// File: rtl/scale_selector.sv
// Scale selector top: two debounced pushbuttons step a saturating scale
// register; every change is followed by an active-low reload pulse that
// makes the downstream divider re-latch the scale.
// Optional feature macro: SCALE_AUTOREPEAT_EN (auto-repeat on held buttons).
module scale_selector
    import scale_selector_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int RELOAD_CYC   = DEF_RELOAD_CYC,
    parameter int SCALE_MIN    = DEF_SCALE_MIN,
    parameter int SCALE_MAX    = DEF_SCALE_MAX,
    parameter int SCALE_INIT   = DEF_SCALE_INIT,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
    input  logic           clk_in,
    input  logic           nrst,
    scale_selector_if.slave bus
);

    localparam int               RCW     = cnt_width(RELOAD_CYC + 1);
    localparam logic [RCW-1:0]   RC_LAST = RCW'(RELOAD_CYC);
    localparam logic [WIDTH:0]   MIN_W   = (WIDTH + 1)'(SCALE_MIN);
    localparam logic [WIDTH:0]   MAX_W   = (WIDTH + 1)'(SCALE_MAX);
    localparam logic [WIDTH-1:0] INIT_S  = WIDTH'(SCALE_INIT);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] scale_q;
    logic [WIDTH-1:0] scale_d;
    logic [RCW-1:0]   reloadCnt_q;
    logic [RCW-1:0]   reloadCnt_d;
    logic             reloadN_q;
    logic             reloadN_d;

    logic             upPress;
    logic             dnPress;
    logic             upLevel_n;
    logic             dnLevel_n;
    logic             upRep;
    logic             dnRep;
    logic             upEv;
    logic             dnEv;

    logic [WIDTH:0]   incWide;
    logic [WIDTH:0]   decWide;
    logic [WIDTH-1:0] incClamped;
    logic [WIDTH-1:0] decClamped;
    logic [WIDTH-1:0] nextScale;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_up (
        .clk_in  (clk_in),
        .nrst    (nrst),
        .btn_n   (bus.btn_up_n),
        .level_n (upLevel_n),
        .press   (upPress)
    );

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_dn (
        .clk_in  (clk_in),
        .nrst    (nrst),
        .btn_n   (bus.btn_dn_n),
        .level_n (dnLevel_n),
        .press   (dnPress)
    );

`ifdef SCALE_AUTOREPEAT_EN
    localparam int             RPW     = cnt_width(REPEAT_CYC);
    localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_CYC - 1);

    logic [RPW-1:0] upRepCnt_q;
    logic [RPW-1:0] dnRepCnt_q;
    logic           upRep_q;
    logic           dnRep_q;
    logic           repHold;

    // Repeat only runs for a single held button while the sequencer is idle
    assign repHold = !(state_q != ST_IDLE) && !(!upLevel_n && !dnLevel_n);

    // Up-button repeat timer: emits an extra press every REPEAT_CYC idle cycles of holding
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            upRepCnt_q <= '0;
            upRep_q    <= 1'b0;
        end else if (upLevel_n || !repHold) begin
            upRepCnt_q <= '0;
            upRep_q    <= 1'b0;
        end else if (upRepCnt_q == RP_LAST) begin
            upRepCnt_q <= '0;
            upRep_q    <= 1'b1;
        end else begin
            upRepCnt_q <= upRepCnt_q + 1'b1;
            upRep_q    <= 1'b0;
        end
    end

    // Down-button repeat timer, same behaviour as the up timer
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            dnRepCnt_q <= '0;
            dnRep_q    <= 1'b0;
        end else if (dnLevel_n || !repHold) begin
            dnRepCnt_q <= '0;
            dnRep_q    <= 1'b0;
        end else if (dnRepCnt_q == RP_LAST) begin
            dnRepCnt_q <= '0;
            dnRep_q    <= 1'b1;
        end else begin
            dnRepCnt_q <= dnRepCnt_q + 1'b1;
            dnRep_q    <= 1'b0;
        end
    end

    assign upRep = upRep_q;
    assign dnRep = dnRep_q;
`else
    assign upRep = 1'b0;
    assign dnRep = 1'b0;
`endif

    assign upEv = upPress | upRep;
    assign dnEv = dnPress | dnRep;

    // Saturating step values, computed one bit wider so neither end can wrap
    always_comb begin
        incWide    = {1'b0, scale_q} + (WIDTH + 1)'(1);
        decWide    = {1'b0, scale_q} - (WIDTH + 1)'(1);
        incClamped = (incWide > MAX_W) ? MAX_W[WIDTH-1:0] : incWide[WIDTH-1:0];
        decClamped = (decWide[WIDTH] || (decWide < MIN_W)) ? MIN_W[WIDTH-1:0]
                                                           : decWide[WIDTH-1:0];
    end

    // Sequencer: take a button event in IDLE, then hold reload_n low for RELOAD_CYC cycles
    always_comb begin
        state_d     = state_q;
        scale_d     = scale_q;
        reloadCnt_d = reloadCnt_q;
        reloadN_d   = reloadN_q;
        nextScale   = scale_q;
        case (state_q)
            ST_IDLE: begin
                reloadN_d   = 1'b1;
                reloadCnt_d = '0;
                if (upEv && dnEv) begin
                    nextScale = INIT_S;
                end else if (upEv) begin
                    nextScale = incClamped;
                end else if (dnEv) begin
                    nextScale = decClamped;
                end
                if (nextScale != scale_q) begin
                    scale_d = nextScale;
                    state_d = ST_RELOAD;
                end
            end
            ST_RELOAD: begin
                if (reloadCnt_q == RC_LAST) begin
                    reloadN_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    reloadN_d   = 1'b0;
                    reloadCnt_d = reloadCnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                reloadN_d = 1'b1;
            end
        endcase
    end

    // State, scale and reload pulse registers; reset aborts any pulse at once
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            scale_q     <= INIT_S;
            reloadCnt_q <= '0;
            reloadN_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            scale_q     <= scale_d;
            reloadCnt_q <= reloadCnt_d;
            reloadN_q   <= reloadN_d;
        end
    end

    assign bus.scale    = scale_q;
    assign bus.reload_n = reloadN_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scale_selector.sv
// Directed bench for scale_selector with short timing constants.
// Build with +define+SCALE_AUTOREPEAT_EN to exercise the auto-repeat variant.
module tb_scale_selector;

    logic clk = 1'b0;
    logic nrst = 1'b0;

    int vecCount  = 0;
    int missCount = 0;
    int pulseCount = 0;
    logic prevReload = 1'b1;

    scale_selector_if #(.WIDTH(8)) bus ();

    scale_selector #(
        .WIDTH        (8),
        .DEBOUNCE_CYC (4),
        .RELOAD_CYC   (3),
        .SCALE_MIN    (1),
        .SCALE_MAX    (6),
        .SCALE_INIT   (4),
        .REPEAT_CYC   (20)
    ) dut (
        .clk_in (clk),
        .nrst   (nrst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Count falling edges of reload_n, sampled on the inactive edge
    always @(negedge clk) begin
        if (prevReload && !bus.reload_n) pulseCount = pulseCount + 1;
        prevReload = bus.reload_n;
    end

    typedef struct {
        logic up;
        logic dn;
        int   expScale;
        int   expPulses;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input int actual, input int expected);
        vecCount++;
        if (actual != expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyReset();
        bus.btn_up_n = 1'b1;
        bus.btn_dn_n = 1'b1;
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    // Press the selected buttons together for 12 cycles, then release and let things settle
    task automatic applyStimulus(input logic up, input logic dn);
        @(negedge clk);
        bus.btn_up_n = ~up;
        bus.btn_dn_n = ~dn;
        repeat (12) @(negedge clk);
        bus.btn_up_n = 1'b1;
        bus.btn_dn_n = 1'b1;
        repeat (14) @(negedge clk);
    endtask

    initial begin
        int firstScale;
        int firstLow;
        int firstBusy;
        int lowCnt;
        int busyCnt;
        int p0;
        int seen;

        vecs[0]  = '{1'b1, 1'b0, 5, 1};
        vecs[1]  = '{1'b1, 1'b0, 6, 1};
        vecs[2]  = '{1'b1, 1'b0, 6, 0};
        vecs[3]  = '{1'b1, 1'b0, 6, 0};
        vecs[4]  = '{1'b1, 1'b1, 4, 1};
        vecs[5]  = '{1'b1, 1'b1, 4, 0};
        vecs[6]  = '{1'b0, 1'b1, 3, 1};
        vecs[7]  = '{1'b0, 1'b1, 2, 1};
        vecs[8]  = '{1'b0, 1'b1, 1, 1};
        vecs[9]  = '{1'b0, 1'b1, 1, 0};
        vecs[10] = '{1'b1, 1'b0, 2, 1};
        vecs[11] = '{1'b1, 1'b1, 4, 1};

        // Reset values
        applyReset();
        checkOutput("reset scale", int'(bus.scale), 4);
        checkOutput("reset reload_n", int'(bus.reload_n), 1);
        checkOutput("reset busy", int'(bus.busy), 0);

        // Single up press: latency, reload width and busy window
        firstScale = -1; firstLow = -1; firstBusy = -1; lowCnt = 0; busyCnt = 0;
        bus.btn_up_n = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (cyc == 10) bus.btn_up_n = 1'b1;
            if (firstScale < 0 && bus.scale != 8'd4) firstScale = cyc;
            if (!bus.reload_n) begin
                lowCnt++;
                if (firstLow < 0) firstLow = cyc;
            end
            if (bus.busy) begin
                busyCnt++;
                if (firstBusy < 0) firstBusy = cyc;
            end
        end
        checkOutput("up scale", int'(bus.scale), 5);
        checkOutput("up scale cycle", firstScale, 7);
        checkOutput("up busy first cycle", firstBusy, 7);
        checkOutput("up reload first low cycle", firstLow, 8);
        checkOutput("up reload low cycles", lowCnt, 3);
        checkOutput("up busy cycles", busyCnt, 4);

        // Bouncing down button followed by a steady hold
        applyReset();
        p0 = pulseCount;
        for (int seg = 0; seg < 6; seg++) begin
            bus.btn_dn_n = (seg % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge clk);
        end
        bus.btn_dn_n = 1'b0;
        repeat (14) @(negedge clk);
        bus.btn_dn_n = 1'b1;
        repeat (14) @(negedge clk);
        checkOutput("bounce scale", int'(bus.scale), 3);
        checkOutput("bounce pulses", pulseCount - p0, 1);

        // Table of presses: saturation at both ends and dual presses
        applyReset();
        for (int i = 0; i < 12; i++) begin
            p0 = pulseCount;
            applyStimulus(vecs[i].up, vecs[i].dn);
            checkOutput($sformatf("vec%0d scale", i), int'(bus.scale), vecs[i].expScale);
            checkOutput($sformatf("vec%0d pulses", i), pulseCount - p0, vecs[i].expPulses);
            checkOutput($sformatf("vec%0d idle", i), int'(bus.busy), 0);
        end

        // Second button accepted during RELOAD is discarded
        p0 = pulseCount;
        @(negedge clk);
        bus.btn_dn_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.btn_up_n = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("busy during second press", int'(bus.busy), 1);
        repeat (6) @(negedge clk);
        bus.btn_up_n = 1'b1;
        bus.btn_dn_n = 1'b1;
        repeat (14) @(negedge clk);
        checkOutput("discard scale", int'(bus.scale), 3);
        checkOutput("discard pulses", pulseCount - p0, 1);

        // Reset asserted in the middle of a reload pulse
        seen = 0;
        bus.btn_up_n = 1'b0;
        for (int cyc = 0; cyc < 20 && seen == 0; cyc++) begin
            @(negedge clk);
            if (!bus.reload_n) seen = 1;
        end
        checkOutput("reload seen before reset", seen, 1);
        #2 nrst = 1'b0;
        #1;
        checkOutput("abort reload_n", int'(bus.reload_n), 1);
        checkOutput("abort scale", int'(bus.scale), 4);
        checkOutput("abort busy", int'(bus.busy), 0);
        bus.btn_up_n = 1'b1;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("after abort scale", int'(bus.scale), 4);

        // Long hold from the lower bound
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("down to min", int'(bus.scale), 1);
        p0 = pulseCount;
        @(negedge clk);
        bus.btn_up_n = 1'b0;
        repeat (70) @(negedge clk);
        bus.btn_up_n = 1'b1;
        repeat (30) @(negedge clk);
`ifdef SCALE_AUTOREPEAT_EN
        checkOutput("hold scale", int'(bus.scale), 4);
        checkOutput("hold pulses", pulseCount - p0, 3);
`else
        checkOutput("hold scale", int'(bus.scale), 2);
        checkOutput("hold pulses", pulseCount - p0, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
